// File: rtl/axis_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axis_stream_fifo_pkg
//  Description : Shared defaults and width helpers for the AXI4-Stream
//                buffer and its storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_stream_fifo_pkg;

  // Default stream data width in bits (always a multiple of 8).
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Default number of beat entries (power of two, >= 2).
  localparam int DEFAULT_DEPTH = 16;

  // One TKEEP bit per data byte.
  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

  // Width of a stored beat: {tdata, tkeep, tlast}.
  function automatic int beat_width(input int data_width);
    return data_width + keep_width(data_width) + 1;
  endfunction

endpackage : axis_stream_fifo_pkg
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_ram
//  Description : DEPTH x WIDTH beat storage. Synchronous write port,
//                asynchronous (combinational) read port so that the owner can
//                present the head entry first-word-fall-through. The array
//                content is deliberately not reset.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   1        write clock
//    wr_en    in   1        write strobe
//    wr_addr  in   ADDR_W   write address
//    wr_data  in   WIDTH    write data
//    rd_addr  in   ADDR_W   read address
//    rd_data  out  WIDTH    read data (combinational from rd_addr)
// ============================================================================
module axis_fifo_ram
  import axis_stream_fifo_pkg::*;
#(
  parameter  int WIDTH  = beat_width(DEFAULT_DATA_WIDTH),
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : axis_fifo_ram
`default_nettype wire

// File: rtl/axis_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_stream_fifo
//  Description : Parametrised AXI4-Stream elastic buffer. Cut-through
//                (first-word fall-through) by default; optional
//                store-and-forward mode that only releases complete packets,
//                with a full-buffer override so packets longer than the
//                buffer still drain instead of deadlocking.
//  Revision    : 1.0 - initial release
//
//  Ports
//    axi_aclk       in   1           clock
//    axi_reset      in   1           asynchronous active-high reset
//    s_axis_tdata   in   DATA_WIDTH  input beat data
//    s_axis_tkeep   in   KEEP_WIDTH  input byte qualifiers
//    s_axis_tlast   in   1           input end of packet
//    s_axis_tvalid  in   1           input beat valid
//    s_axis_tready  out  1           buffer can accept a beat (registered)
//    m_axis_tdata   out  DATA_WIDTH  output beat data
//    m_axis_tkeep   out  KEEP_WIDTH  output byte qualifiers
//    m_axis_tlast   out  1           output end of packet
//    m_axis_tvalid  out  1           output beat valid
//    m_axis_tready  in   1           downstream accepts
//    fill_level     out  CNT_W       stored beats
//    pkt_count      out  CNT_W       stored beats carrying TLAST
// ============================================================================
module axis_stream_fifo
  import axis_stream_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH       = DEFAULT_DEPTH,
  parameter  int PACKET_MODE = 0,
  localparam int KEEP_WIDTH  = keep_width(DATA_WIDTH),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,

  output logic [CNT_W-1:0]      fill_level,
  output logic [CNT_W-1:0]      pkt_count
);

  localparam int               c_addr_w = $clog2(DEPTH);
  localparam int               c_beat_w = beat_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_full   = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
  } axis_beat_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]    r_fill;
  logic [CNT_W-1:0]    r_pkt;
  logic                r_s_ready;

  // --------------------------------------------------------------------------
  // Handshake and next-state arithmetic
  // --------------------------------------------------------------------------
  logic                w_push;
  logic                w_pop;
  logic                w_m_valid;
  logic [CNT_W-1:0]    w_fill_next;
  logic [CNT_W-1:0]    w_pkt_next;
  axis_beat_t          w_wr_beat;
  axis_beat_t          w_rd_beat;
  logic [c_beat_w-1:0] w_rd_data;

  assign w_push = s_axis_tvalid & r_s_ready;
  assign w_pop  = w_m_valid & m_axis_tready;

  assign w_fill_next = r_fill + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_pkt_next  = r_pkt
                     + CNT_W'(w_push & s_axis_tlast)
                     - CNT_W'(w_pop & w_rd_beat.tlast);

  assign w_wr_beat.tdata = s_axis_tdata;
  assign w_wr_beat.tkeep = s_axis_tkeep;
  assign w_wr_beat.tlast = s_axis_tlast;

  // --------------------------------------------------------------------------
  // Pointers, counters and registered ready.
  // Ready is derived from the next fill level so it is a clean flop output;
  // the price is a one-cycle bubble after a pop at full.
  // --------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_pkt     <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      r_fill    <= w_fill_next;
      r_pkt     <= w_pkt_next;
      r_s_ready <= (w_fill_next != c_full);
    end
  end

  // --------------------------------------------------------------------------
  // Output valid generation
  // --------------------------------------------------------------------------
  generate
    if (PACKET_MODE != 0) begin : g_packet
      // Set once the buffer has filled without a complete packet; keeps the
      // oversize packet streaming cut-through after the first pop drops the
      // level below full. Cleared when that packet's TLAST leaves or the
      // buffer drains, after which complete-packet gating resumes.
      logic r_release;

      always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
          r_release <= 1'b0;
        end else if ((w_pop && w_rd_beat.tlast) || (w_fill_next == '0)) begin
          r_release <= 1'b0;
        end else if (r_fill == c_full) begin
          r_release <= 1'b1;
        end
      end

      assign w_m_valid = (r_fill != '0) &&
                         ((r_pkt != '0) || (r_fill == c_full) || r_release);
    end else begin : g_cut_through
      assign w_m_valid = (r_fill != '0);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  axis_fifo_ram #(
    .WIDTH (c_beat_w),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (axi_aclk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_beat),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  assign w_rd_beat = axis_beat_t'(w_rd_data);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tdata  = w_rd_beat.tdata;
  assign m_axis_tkeep  = w_rd_beat.tkeep;
  assign m_axis_tlast  = w_rd_beat.tlast;
  assign fill_level    = r_fill;
  assign pkt_count     = r_pkt;

endmodule : axis_stream_fifo
`default_nettype wire

// File: doc/axis_stream_fifo.md
Name: axis_stream_fifo

Overview:
Parametrised AXI4-Stream buffer between the DMA MM2S/S2MM stream ports and stream endpoints. Generalises the stream channel: configurable data width with derived TKEEP width, configurable depth, and an optional store-and-forward packet mode gated on TLAST. Used in the verification environment as a loopback element between MM2S and S2MM, and reusable in RTL as a stream elastic buffer.

Parameters:
DATA_WIDTH, 32, TDATA width in bits; multiple of 8; KEEP_WIDTH = DATA_WIDTH/8.
DEPTH, 16, number of beat entries; power of two, >= 2.
PACKET_MODE, 0, 0 = cut-through (first-word fall-through); 1 = store-and-forward (release only complete packets).

Ports:
axi_aclk  in  1  clock.
axi_reset  in  1  asynchronous active-high reset.
s_axis_tdata  in  DATA_WIDTH  input beat data.
s_axis_tkeep  in  KEEP_WIDTH  input byte qualifiers.
s_axis_tlast  in  1  input end of packet.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  buffer can accept a beat.
m_axis_tdata  out  DATA_WIDTH  output beat data.
m_axis_tkeep  out  KEEP_WIDTH  output byte qualifiers.
m_axis_tlast  out  1  output end of packet.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream accepts.
fill_level  out  $clog2(DEPTH)+1  stored beats.
pkt_count  out  $clog2(DEPTH)+1  complete packets (TLAST beats) stored.

Behaviour:
- Clock is axi_aclk; reset is asynchronous and active-high on axi_reset. All state clears immediately on assertion: pointers = 0, fill_level = 0, pkt_count = 0, s_axis_tready = 0, m_axis_tvalid = 0. m_axis_tdata/tkeep/tlast are don't-care while tvalid = 0.
- Storage: DEPTH-entry array of {tdata, tkeep, tlast}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready. Both evaluated at the same posedge.
- fill_level_next = fill_level + push - pop. pkt_count_next = pkt_count + (push & s_axis_tlast) - (pop & m_axis_tlast).
- s_axis_tready is registered: it equals (fill_level_next != DEPTH) and is 0 in the cycle of reset. It goes high on the first posedge after reset deasserts.
- Full: s_axis_tready = 0, so no push can occur. A pop at full raises tready on the next cycle (one-cycle bubble is acceptable and required).
- Empty: m_axis_tvalid = 0. A simultaneous push and pop is impossible because tvalid is low.
- Latency, cut-through mode: a beat pushed at edge N is presented (m_axis_tvalid = 1) after edge N, i.e. it is poppable at edge N+1.
- Output data is read combinationally from the array at the read pointer (FWFT).
- Packet mode: m_axis_tvalid = (fill_level != 0) & ((pkt_count != 0) | (fill_level == DEPTH)).
- The full override releases packets longer than DEPTH beats in cut-through fashion, so the buffer cannot deadlock. Once release starts under override, it continues beat by beat while fill_level != 0.
- Cut-through mode: m_axis_tvalid = (fill_level != 0).
- AXIS rules: once m_axis_tvalid is asserted, it and the data stay stable until pop. Data is never reordered or dropped. TKEEP passes through unmodified, including null bytes.
- Reset mid-packet discards all stored beats. The partial packet is not completed, and no TLAST is synthesised.

Decomposition:
- Shared package (params_pkg): DATA_WIDTH default, a derived KEEP_WIDTH function, and a typedef axis_beat_t {tdata, tkeep, tlast} parametrised via a localparam in the module.
- One natural sub-module: axis_fifo_ram. It is the DEPTH x beat storage array with a synchronous write port and an asynchronous read port, and holds no reset on the data.
- Pointer, level, packet-count and ready/valid logic stay in the top.

Test Plan:
- Reset, then push 16 beats 0x00..0x0F (cut-through, DEPTH = 16) with m_axis_tready = 0 -> fill_level = 16 and s_axis_tready = 0 after the 16th push; releasing tready pops 0x00..0x0F in order, and s_axis_tready = 1 one cycle after the first pop.
- Packet mode: push 3 beats with TLAST on beat 3 and m_axis_tready = 1 -> m_axis_tvalid stays 0 until the edge after beat 3, then 3 beats emerge with TLAST only on the third; pkt_count returns 1 -> 0.
- Packet mode: push 20 beats without TLAST, then TLAST on beat 21 -> tvalid asserts when fill_level = 16; all 21 beats arrive intact and in order with no deadlock.
- Randomised tvalid/tready at 50% each, 1000 beats, TKEEP random including 4'b0000 -> scoreboard shows exact data/keep/last match, and valid/data never change while stalled.
- Assert axi_reset asynchronously mid-packet with fill_level = 7 -> outputs clear within the same cycle with no clock needed; after deassertion the FIFO is empty and a new 2-beat packet passes correctly.
- DATA_WIDTH = 64, DEPTH = 4 build -> KEEP_WIDTH = 8; back-to-back simultaneous push/pop at fill_level = 2 keeps fill_level at 2 for 10 cycles.
